apple_gen: RTL and testbench
============================

APPLE_GEN -- requirements
Module: apple_gen

Interface
REQ-001 SHALL have port CLK_50M  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port eat_pulse  input  1  one-cycle pulse, head reached the apple (add_cube).
REQ-004 SHALL have port restart  input  1  one-cycle pulse, new game requested.
REQ-005 SHALL have port occ_query_valid  output  1  body-occupancy probe strobe, one cycle.
REQ-006 SHALL have port occ_query_x  output  6  probe cell column.
REQ-007 SHALL have port occ_query_y  output  5  probe cell row.
REQ-008 SHALL have port occ_hit  input  1  probed cell is occupied; sampled exactly one cycle after occ_query_valid.
REQ-009 SHALL have port apple_x  output  6  apple cell column, to display and eat-detect logic.
REQ-010 SHALL have port apple_y  output  5  apple cell row.
REQ-011 SHALL have port apple_valid  output  1  apple position stable and drawable.
REQ-012 SHALL have port busy  output  1  placement in progress.

Function
REQ-013 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle in all states.
REQ-014 SHALL use a grid of 40x30 cells; legal apple cells are x 1..38, y 1..28 (wall cells excluded).
REQ-015 SHALL implement states IDLE, DRAW, PROBE, WAIT, PLACE; IDLE is entered after reset.
REQ-016 IDLE: on eat_pulse, SHALL go to DRAW, clear apple_valid, set busy, clear the retry counter.
REQ-017 DRAW: candidate x = lfsr[5:0], y = lfsr[12:8]; if illegal, SHALL stay in DRAW (redraw next cycle, no retry count); if legal, SHALL latch the candidate and go to PROBE.
REQ-018 PROBE: SHALL assert occ_query_valid for one cycle with the latched candidate, go to WAIT.
REQ-019 WAIT: occ_hit=0 SHALL go to PLACE; occ_hit=1 SHALL increment a 5-bit retry counter and go to DRAW.
REQ-020 When the retry counter reaches 31 on a hit, SHALL go to PLACE with fallback cell (20,15).
REQ-021 PLACE: SHALL update apple_x/apple_y, set apple_valid, clear busy, return to IDLE; total latency from eat_pulse to apple_valid is at least 4 cycles.
REQ-022 eat_pulse while busy SHALL set a one-deep pending flag; on PLACE with pending set, SHALL clear it and re-enter DRAW instead of IDLE (apple_valid pulses high one cycle).
REQ-023 restart in any state SHALL force IDLE, apple to (24,10), apple_valid=1, busy=0, pending and retry cleared; restart wins over a simultaneous eat_pulse.
REQ-024 apple_x/apple_y SHALL change only in PLACE, on restart, or on reset; never hold an illegal value.
REQ-025 occ_query_x/occ_query_y SHALL hold the last latched candidate when occ_query_valid is low.

Reset
REQ-026 RST high SHALL immediately set: state IDLE, lfsr 16'hACE1, apple_x 24, apple_y 10, apple_valid 1, busy 0, occ_query_valid 0, occ_query_x 0, occ_query_y 0, retry 0, pending 0.
REQ-027 RST asserted mid-placement SHALL abandon the placement with no query issued after release until a new eat_pulse.

Configuration
REQ-028 With macro APPLE_OCC_CHECK_EN defined, SHALL implement PROBE/WAIT and the occupancy handshake as above.
REQ-029 Without APPLE_OCC_CHECK_EN, DRAW with a legal candidate SHALL go directly to PLACE (latency 2 cycles minimum), occ_query_valid SHALL be tied 0, occ_hit ignored, retry logic absent.

Verification
REQ-030 Reset release -> apple (24,10), apple_valid=1, busy=0, lfsr=16'hACE1 first cycle.
REQ-031 eat_pulse, occ_hit held 0 -> one occ_query_valid with legal cell, apple_valid=1 at that cell, busy falls, all in <=40 cycles.
REQ-032 eat_pulse, occ_hit held 1 -> exactly 31 queries, then apple (20,15), apple_valid=1.
REQ-033 Second eat_pulse during WAIT -> two placements back-to-back, apple_valid low between them except one-cycle PLACE pulse.
REQ-034 restart coincident with eat_pulse in DRAW -> next cycle IDLE, apple (24,10), busy=0, no further query.
REQ-035 Build without APPLE_OCC_CHECK_EN, eat_pulse -> occ_query_valid never high, new legal apple within 40 cycles.

Source files
------------

// File: rtl/apple_gen.sv
// Apple placement generator: draws random legal cells from a 16-bit LFSR and publishes the apple.
// Define APPLE_OCC_CHECK_EN to probe body occupancy (PROBE/WAIT) before accepting a cell.
module apple_gen (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic        eat_pulse,
  input  logic        restart,
  output logic        occ_query_valid,
  output logic [5:0]  occ_query_x,
  output logic [4:0]  occ_query_y,
  input  logic        occ_hit,
  output logic [5:0]  apple_x,
  output logic [4:0]  apple_y,
  output logic        apple_valid,
  output logic        busy,
  output logic [2:0]  state_dbg,
  output logic [15:0] lfsr_dbg
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DRAW  = 3'd1;
  localparam logic [2:0] PLACE = 3'd4;

  localparam logic [5:0]  START_X   = 6'd24;
  localparam logic [4:0]  START_Y   = 5'd10;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [2:0]  state;
  logic [15:0] lfsr;
  logic        pending;
  logic [5:0]  draw_x;
  logic [4:0]  draw_y;
  logic        draw_legal;

  assign draw_x     = lfsr[5:0];
  assign draw_y     = lfsr[12:8];
  // Wall ring is excluded: columns 0 and 39, rows 0 and 29.
  assign draw_legal = (draw_x >= 6'd1) && (draw_x <= 6'd38) &&
                      (draw_y >= 5'd1) && (draw_y <= 5'd28);

  assign state_dbg = state;
  assign lfsr_dbg  = lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; free-running in every state.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

`ifdef APPLE_OCC_CHECK_EN
  localparam logic [2:0] PROBE  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [5:0] FALL_X = 6'd20;
  localparam logic [4:0] FALL_Y = 5'd15;

  logic [4:0] retry;
  logic       fallback;

  // Probe handshake: occ_query_valid is high for exactly the PROBE cycle with the cell on
  // occ_query_x/y; occ_hit is sampled only in the following (WAIT) cycle, no back-pressure.
  assign occ_query_valid = (state == PROBE);
`else
  logic unused_occ_hit;
  assign unused_occ_hit  = occ_hit;
  assign occ_query_valid = 1'b0;
`endif

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      apple_x     <= START_X;
      apple_y     <= START_Y;
      apple_valid <= 1'b1;
      busy        <= 1'b0;
      occ_query_x <= 6'd0;
      occ_query_y <= 5'd0;
      pending     <= 1'b0;
`ifdef APPLE_OCC_CHECK_EN
      retry       <= 5'd0;
      fallback    <= 1'b0;
`endif
    end else if (restart) begin
      state       <= IDLE;
      apple_x     <= START_X;
      apple_y     <= START_Y;
      apple_valid <= 1'b1;
      busy        <= 1'b0;
      pending     <= 1'b0;
`ifdef APPLE_OCC_CHECK_EN
      retry       <= 5'd0;
      fallback    <= 1'b0;
`endif
    end else begin
      if (eat_pulse && busy) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (eat_pulse) begin
            state       <= DRAW;
            apple_valid <= 1'b0;
            busy        <= 1'b1;
`ifdef APPLE_OCC_CHECK_EN
            retry       <= 5'd0;
            fallback    <= 1'b0;
`endif
          end
        end
        DRAW: begin
          // Also ends the one-cycle apple_valid pulse of a back-to-back placement.
          apple_valid <= 1'b0;
          if (draw_legal) begin
            occ_query_x <= draw_x;
            occ_query_y <= draw_y;
`ifdef APPLE_OCC_CHECK_EN
            state       <= PROBE;
`else
            state       <= PLACE;
`endif
          end
        end
`ifdef APPLE_OCC_CHECK_EN
        PROBE: state <= WAIT;
        WAIT: begin
          if (!occ_hit) begin
            state <= PLACE;
          end else if (retry == 5'd30) begin
            retry    <= 5'd31;
            fallback <= 1'b1;
            state    <= PLACE;
          end else begin
            retry <= retry + 5'd1;
            state <= DRAW;
          end
        end
`endif
        PLACE: begin
`ifdef APPLE_OCC_CHECK_EN
          apple_x  <= fallback ? FALL_X : occ_query_x;
          apple_y  <= fallback ? FALL_Y : occ_query_y;
          fallback <= 1'b0;
`else
          apple_x  <= occ_query_x;
          apple_y  <= occ_query_y;
`endif
          apple_valid <= 1'b1;
          // An eat arriving in this very cycle is treated like a pending one.
          if (pending || eat_pulse) begin
            pending <= 1'b0;
            state   <= DRAW;
`ifdef APPLE_OCC_CHECK_EN
            retry   <= 5'd0;
`endif
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_gen.sv
// Self-checking bench for apple_gen: randomized eat/occupancy stimulus against a reference model
// built from the LFSR stream and the cell-legality rule. Follows the APPLE_OCC_CHECK_EN build.
module tb_apple_gen;

  logic        CLK_50M;
  logic        RST;
  logic        eat_pulse;
  logic        restart;
  logic        occ_query_valid;
  logic [5:0]  occ_query_x;
  logic [4:0]  occ_query_y;
  logic        occ_hit;
  logic [5:0]  apple_x;
  logic [4:0]  apple_y;
  logic        apple_valid;
  logic        busy;
  logic [2:0]  unused_state_dbg;
  logic [15:0] lfsr_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] m_lfsr;

  apple_gen dut (
    .CLK_50M(CLK_50M), .RST(RST), .eat_pulse(eat_pulse), .restart(restart),
    .occ_query_valid(occ_query_valid), .occ_query_x(occ_query_x), .occ_query_y(occ_query_y),
    .occ_hit(occ_hit), .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
    .busy(busy), .state_dbg(unused_state_dbg), .lfsr_dbg(lfsr_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK_50M = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  function automatic bit cell_ok(input int x, input int y);
    return (x >= 1) && (x <= 38) && (y >= 1) && (y <= 28);
  endfunction

  // Steps until the stream starting at v0 yields a legal cell, plus that cell.
  function automatic int first_legal(input logic [15:0] v0, output logic [5:0] x,
                                     output logic [4:0] y);
    logic [15:0] v;
    int k;
    v = v0;
    k = 0;
    while (!cell_ok(int'(v[5:0]), int'(v[12:8])) && k < 1000) begin
      v = lfsr_step(v);
      k++;
    end
    x = v[5:0];
    y = v[12:8];
    return k;
  endfunction

  always @(posedge CLK_50M or posedge RST) begin
    if (RST) m_lfsr = 16'hACE1;
    else     m_lfsr = lfsr_step(m_lfsr);
  end

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK_50M);
    RST = 1'b0;
    check_val("rst_apple", {apple_x, apple_y}, {6'd24, 5'd10});
    check_val("rst_valid", apple_valid, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_qvalid", occ_query_valid, 0);
    check_val("rst_qcell", {occ_query_x, occ_query_y}, 0);
    check_val("rst_lfsr", lfsr_dbg, 16'hACE1);
  endtask

  task automatic run_placement(input int hit_pct, input string tag);
    logic [5:0]  ex;
    logic [4:0]  ey;
    logic [10:0] prev;
    int k, cyc, hits, queries, bad_mid, exp_q;
    bit fb, done;
    prev = {apple_x, apple_y};
    hits = 0; queries = 0; bad_mid = 0; cyc = 0; fb = 0; done = 0;
    occ_hit = 1'b0;
    eat_pulse = 1'b1;
    @(negedge CLK_50M);
    eat_pulse = 1'b0;
    k = first_legal(m_lfsr, ex, ey);
    while (cyc < 400) begin
      if (apple_valid && !busy) begin
        done = 1;
        break;
      end
      if (apple_valid || ({apple_x, apple_y} != prev)) bad_mid++;
      if (occ_query_valid) begin
        queries++;
        check_val({tag, "_qcell"}, {occ_query_x, occ_query_y}, {ex, ey});
        occ_hit = ($urandom_range(99) < hit_pct);
        if (occ_hit) begin
          hits++;
          if (hits == 31) begin
            fb = 1; ex = 6'd20; ey = 5'd15;
          end else begin
            void'(first_legal(lfsr_step(lfsr_step(m_lfsr)), ex, ey));
          end
        end
      end
      @(negedge CLK_50M);
      cyc++;
    end
    occ_hit = 1'b0;
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_apple"}, {apple_x, apple_y}, {ex, ey});
    check_val({tag, "_mid"}, bad_mid, 0);
    check_val({tag, "_lfsr"}, lfsr_dbg, m_lfsr);
`ifdef APPLE_OCC_CHECK_EN
    exp_q = fb ? hits : hits + 1;
    if (hits == 0) check_val({tag, "_lat"}, cyc, k + 4);
`else
    exp_q = 0;
    check_val({tag, "_lat"}, cyc, k + 2);
`endif
    check_val({tag, "_queries"}, queries, exp_q);
  endtask

  task automatic wait_query(input string tag);
    int cyc;
    cyc = 0;
    while (!occ_query_valid && cyc < 200) begin
      @(negedge CLK_50M);
      cyc++;
    end
    check_val({tag, "_seen"}, occ_query_valid, 1);
  endtask

  // Second eat during WAIT: two placements, apple_valid pulses one cycle between them.
  task automatic run_pending();
    logic [5:0] x1, x2;
    logic [4:0] y1, y2;
    int cyc;
    occ_hit = 1'b0;
    eat_pulse = 1'b1;
    @(negedge CLK_50M);
    eat_pulse = 1'b0;
    void'(first_legal(m_lfsr, x1, y1));
    wait_query("pend1");
    check_val("pend_q1", {occ_query_x, occ_query_y}, {x1, y1});
    @(negedge CLK_50M);
    eat_pulse = 1'b1;
    @(negedge CLK_50M);
    eat_pulse = 1'b0;
    cyc = 0;
    while (!apple_valid && cyc < 50) begin
      @(negedge CLK_50M);
      cyc++;
    end
    check_val("pend_pulse", apple_valid, 1);
    check_val("pend_busy", busy, 1);
    check_val("pend_apple1", {apple_x, apple_y}, {x1, y1});
    void'(first_legal(m_lfsr, x2, y2));
    @(negedge CLK_50M);
    check_val("pend_pulse_end", apple_valid, 0);
    wait_query("pend2");
    check_val("pend_q2", {occ_query_x, occ_query_y}, {x2, y2});
    cyc = 0;
    while (!(apple_valid && !busy) && cyc < 50) begin
      @(negedge CLK_50M);
      cyc++;
    end
    check_val("pend_done", apple_valid && !busy, 1);
    check_val("pend_apple2", {apple_x, apple_y}, {x2, y2});
  endtask

  task automatic run_restart();
    int q;
    eat_pulse = 1'b1;
    @(negedge CLK_50M);
    eat_pulse = 1'b1;
    restart = 1'b1;
    @(negedge CLK_50M);
    eat_pulse = 1'b0;
    restart = 1'b0;
    check_val("rs_apple", {apple_x, apple_y}, {6'd24, 5'd10});
    check_val("rs_valid", apple_valid, 1);
    check_val("rs_busy", busy, 0);
    q = 0;
    repeat (12) begin
      if (occ_query_valid || busy) q++;
      @(negedge CLK_50M);
    end
    check_val("rs_quiet", q, 0);
  endtask

  task automatic run_mid_reset();
    int q;
    eat_pulse = 1'b1;
    @(negedge CLK_50M);
    eat_pulse = 1'b0;
    @(negedge CLK_50M);
    #3 RST = 1'b1;
    #1;
    check_val("mr_apple", {apple_x, apple_y}, {6'd24, 5'd10});
    check_val("mr_valid", apple_valid, 1);
    check_val("mr_busy", busy, 0);
    @(negedge CLK_50M);
    RST = 1'b0;
    check_val("mr_lfsr", lfsr_dbg, 16'hACE1);
    q = 0;
    repeat (12) begin
      if (occ_query_valid || busy) q++;
      @(negedge CLK_50M);
    end
    check_val("mr_quiet", q, 0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    eat_pulse = 1'b0;
    restart   = 1'b0;
    occ_hit   = 1'b0;
    RST       = 1'b1;
    do_reset();
    repeat (3) @(negedge CLK_50M);
    run_placement(0, "clear");
`ifdef APPLE_OCC_CHECK_EN
    run_placement(100, "blocked");
`endif
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 6)) @(negedge CLK_50M);
      run_placement(int'($urandom_range(2)) * 40, "rnd");
    end
`ifdef APPLE_OCC_CHECK_EN
    repeat (2) @(negedge CLK_50M);
    run_pending();
`endif
    repeat (2) @(negedge CLK_50M);
    run_restart();
    run_mid_reset();
    run_placement(0, "post");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
